decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_pkg.sv | 57 +++++
 rtl/decode_imm_gen.sv | 54 +++++
 rtl/decode.sv | 202 ++++++++++++++++++++
 tb/tb_decode.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode/execute definitions: opcodes, ALU codes, immediate formats.
// Also holds the funct3-to-ALU mapping that R-type and I-type ALU ops use.
package decode_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_e;

    // alt selects SUB for funct3=0 and SRA for funct3=5
    function automatic alu_e alu_from_f3(input logic [2:0] f3,
                                         input logic alt);
        alu_e a;
        unique case (f3)
            3'd0:    a = alt ? ALU_SUB : ALU_ADD;
            3'd1:    a = ALU_SLL;
            3'd2:    a = ALU_SLT;
            3'd3:    a = ALU_SLTU;
            3'd4:    a = ALU_XOR;
            3'd5:    a = alt ? ALU_SRA : ALU_SRL;
            3'd6:    a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: extracts and sign-extends the RV32I immediate
// and reports which format it came from.
module imm_gen
    import decode_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int INST_LEN = 32
) (
    input  logic [INST_LEN-1:0] instr,
    output logic [WORD-1:0]     imm,
    output logic [2:0]          imm_id
);

    logic [31:0] i;
    logic [31:0] raw;
    logic [6:0]  opc;

    assign i   = instr[31:0];
    assign opc = i[6:0];

    always_comb begin
        raw    = '0;
        imm_id = IMM_NONE;
        unique case (1'b1)
            (opc == OP_IMM), (opc == OP_LOAD), (opc == OP_JALR): begin
                raw    = {{20{i[31]}}, i[31:20]};
                imm_id = IMM_I;
            end
            (opc == OP_STORE): begin
                raw    = {{20{i[31]}}, i[31:25], i[11:7]};
                imm_id = IMM_S;
            end
            (opc == OP_BRANCH): begin
                raw    = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                imm_id = IMM_B;
            end
            (opc == OP_LUI), (opc == OP_AUIPC): begin
                raw    = {i[31:12], 12'b0};
                imm_id = IMM_U;
            end
            (opc == OP_JAL): begin
                raw    = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                imm_id = IMM_J;
            end
            default: begin
                raw    = '0;
                imm_id = IMM_NONE;
            end
        endcase
    end

    assign imm = WORD'($signed(raw));

endmodule

// File: rtl/decode.sv
// RV32I decode stage: combinational decode feeding a single
// valid/ready pipeline register toward execute.
module decode
    import decode_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_valid_i,
    output logic                if_ready_o,
    input  logic [INST_LEN-1:0] instr_i,
    input  logic [WORD-1:0]     pc_i,
    input  logic                flush_i,
    output logic                ex_valid_o,
    input  logic                ex_ready_i,
    output logic [WORD-1:0]     pc_o,
    output logic [REG_W-1:0]    rs1,
    output logic [REG_W-1:0]    rs2,
    output logic [REG_W-1:0]    rd,
    output logic                opsel1,
    output logic                opsel2,
    output logic [3:0]          alu_func,
    output logic [WORD-1:0]     imm,
    output logic [2:0]          imm_id,
    output logic                rf_wen,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic                branch,
    output logic                jump,
    output logic [2:0]          mem_size,
    output logic                illegal_o
);

    typedef struct packed {
        logic [WORD-1:0]  pc;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             opsel1;
        logic             opsel2;
        logic [3:0]       alu;
        logic [WORD-1:0]  imm;
        logic [2:0]       imm_id;
        logic             rf_wen;
        logic             mem_ren;
        logic             mem_wen;
        logic             branch;
        logic             jump;
        logic [2:0]       mem_size;
        logic             illegal;
    } bundle_t;

    bundle_t         d;
    bundle_t         q;
    logic [31:0]     ins;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [WORD-1:0] imm_w;
    logic [2:0]      imm_id_w;
    logic            legal;
    logic            wr;
    logic            accept;

    assign ins = instr_i[31:0];
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    imm_gen #(
        .WORD     (WORD),
        .INST_LEN (INST_LEN)
    ) u_imm_gen (
        .instr  (instr_i),
        .imm    (imm_w),
        .imm_id (imm_id_w)
    );

    always_comb begin
        d        = '0;
        d.pc     = pc_i;
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.rd     = ins[11:7];
        d.imm    = imm_w;
        d.imm_id = imm_id_w;
        d.alu    = ALU_ADD;
        legal    = 1'b1;
        wr       = 1'b0;
        unique case (1'b1)
            (opc == OP_LUI): begin
                wr       = 1'b1;
                d.opsel2 = 1'b1;
                d.alu    = ALU_PASSB;
            end
            (opc == OP_AUIPC): begin
                wr       = 1'b1;
                d.opsel1 = 1'b1;
                d.opsel2 = 1'b1;
            end
            (opc == OP_JAL): begin
                wr       = 1'b1;
                d.jump   = 1'b1;
                d.opsel1 = 1'b1;
                d.opsel2 = 1'b1;
            end
            (opc == OP_JALR): begin
                wr       = 1'b1;
                d.jump   = 1'b1;
                d.opsel2 = 1'b1;
                legal    = (f3 == 3'd0);
            end
            (opc == OP_BRANCH): begin
                d.branch = 1'b1;
                unique case (f3)
                    3'd0, 3'd1: d.alu = ALU_SUB;
                    3'd4, 3'd5: d.alu = ALU_SLT;
                    3'd6, 3'd7: d.alu = ALU_SLTU;
                    default:    legal = 1'b0;
                endcase
            end
            (opc == OP_LOAD): begin
                wr         = 1'b1;
                d.mem_ren  = 1'b1;
                d.opsel2   = 1'b1;
                d.mem_size = f3;
                legal      = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            (opc == OP_STORE): begin
                d.mem_wen  = 1'b1;
                d.opsel2   = 1'b1;
                d.mem_size = f3;
                legal      = (f3 <= 3'd2);
            end
            (opc == OP_IMM): begin
                wr       = 1'b1;
                d.opsel2 = 1'b1;
                d.alu    = alu_from_f3(f3, (f3 == 3'd5) && f7[5]);
                if (f3 == 3'd1)
                    legal = (f7 == 7'h00);
                else if (f3 == 3'd5)
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
            end
            (opc == OP_REG): begin
                wr    = 1'b1;
                d.alu = alu_from_f3(f3, f7[5]);
                legal = (f7 == 7'h00) ||
                        ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            default: legal = 1'b0;
        endcase
        d.rf_wen = wr && legal && (d.rd != '0);
        // Illegal beats still travel down the pipe, but with no side effects
        if (!legal) begin
            d.illegal = 1'b1;
            d.mem_ren = 1'b0;
            d.mem_wen = 1'b0;
            d.branch  = 1'b0;
            d.jump    = 1'b0;
            d.alu     = ALU_ADD;
            d.opsel1  = 1'b0;
            d.opsel2  = 1'b0;
        end
    end

    assign if_ready_o = !ex_valid_o || ex_ready_i;
    assign accept     = if_valid_i && if_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= '0;
            ex_valid_o <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (accept) begin
            q          <= d;
            ex_valid_o <= 1'b1;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    assign pc_o      = q.pc;
    assign rs1       = q.rs1;
    assign rs2       = q.rs2;
    assign rd        = q.rd;
    assign opsel1    = q.opsel1;
    assign opsel2    = q.opsel2;
    assign alu_func  = q.alu;
    assign imm       = q.imm;
    assign imm_id    = q.imm_id;
    assign rf_wen    = q.rf_wen;
    assign mem_ren   = q.mem_ren;
    assign mem_wen   = q.mem_wen;
    assign branch    = q.branch;
    assign jump      = q.jump;
    assign mem_size  = q.mem_size;
    assign illegal_o = q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: table of instructions with hand-decoded
// fields, then stall, flush and reset-in-stall sequences.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] pc_o;
    logic [4:0]  rs1, rs2, rd;
    logic        opsel1, opsel2;
    logic [3:0]  alu_func;
    logic [31:0] imm;
    logic [2:0]  imm_id;
    logic        rf_wen, mem_ren, mem_wen, branch, jump;
    logic [2:0]  mem_size;
    logic        illegal_o;

    always #5 clk = ~clk;

    decode dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid_i (if_valid_i),
        .if_ready_o (if_ready_o),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .ex_valid_o (ex_valid_o),
        .ex_ready_i (ex_ready_i),
        .pc_o       (pc_o),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .opsel1     (opsel1),
        .opsel2     (opsel2),
        .alu_func   (alu_func),
        .imm        (imm),
        .imm_id     (imm_id),
        .rf_wen     (rf_wen),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .branch     (branch),
        .jump       (jump),
        .mem_size   (mem_size),
        .illegal_o  (illegal_o)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        o1;
        logic        o2;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [2:0]  id;
        logic        wen;
        logic        mren;
        logic        mwen;
        logic        br;
        logic        j;
        logic [2:0]  msz;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    vec_t v[14];
    int   total = 0;
    int   bad   = 0;
    exp_t snap;

    function automatic exp_t act();
        exp_t a;
        a = '{rd, rs1, rs2, opsel1, opsel2, alu_func, imm, imm_id,
              rf_wen, mem_ren, mem_wen, branch, jump, mem_size, illegal_o};
        return a;
    endfunction

    task automatic chk(input string nm, input logic [95:0] a,
                       input logic [95:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rd  rs1 rs2 o1 o2 alu imm           id wen mr mw br j msz ill
        v[0]  = '{"addi",  32'hFFD08293, '{5'd5, 5'd1, 5'd29, 1'b0, 1'b1, 4'd0, 32'hFFFFFFFD, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}};
        v[1]  = '{"lui",   32'h123451B7, '{5'd3, 5'd8, 5'd3, 1'b0, 1'b1, 4'd10, 32'h12345000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}};
        v[2]  = '{"sw",    32'h0020A423, '{5'd8, 5'd1, 5'd2, 1'b0, 1'b1, 4'd0, 32'h00000008, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0}};
        v[3]  = '{"ill",   32'hFFFFFFFF, '{5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 4'd0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}};
        v[4]  = '{"add",   32'h002081B3, '{5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 4'd0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}};
        v[5]  = '{"sub",   32'h402081B3, '{5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 4'd1, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}};
        v[6]  = '{"srai",  32'h4030D293, '{5'd5, 5'd1, 5'd3, 1'b0, 1'b1, 4'd7, 32'h00000403, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}};
        v[7]  = '{"blt",   32'hFE20CEE3, '{5'd29, 5'd1, 5'd2, 1'b0, 1'b0, 4'd3, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}};
        v[8]  = '{"jal",   32'h010000EF, '{5'd1, 5'd0, 5'd16, 1'b1, 1'b1, 4'd0, 32'h00000010, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}};
        v[9]  = '{"jalr",  32'h00008067, '{5'd0, 5'd1, 5'd0, 1'b0, 1'b1, 4'd0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}};
        v[10] = '{"lw",    32'hFF812303, '{5'd6, 5'd2, 5'd24, 1'b0, 1'b1, 4'd0, 32'hFFFFFFF8, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0}};
        v[11] = '{"auipc", 32'hFFFFF217, '{5'd4, 5'd31, 5'd31, 1'b1, 1'b1, 4'd0, 32'hFFFFF000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}};
        v[12] = '{"illf7", 32'h402091B3, '{5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 4'd0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}};
        v[13] = '{"nop",   32'h00000013, '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'd0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}};

        reset      = 1'b1;
        if_valid_i = 1'b1;
        instr_i    = 32'hFFFFFFFF;
        pc_i       = 32'h0000_0040;
        flush_i    = 1'b0;
        ex_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_valid", 96'(ex_valid_o), 96'(1'b0));
        chk("rst_payload", 96'(act()), 96'(0));
        chk("rst_pc", 96'(pc_o), 96'(0));
        reset      = 1'b0;
        if_valid_i = 1'b0;
        #1;
        chk("rst_ready", 96'(if_ready_o), 96'(1'b1));

        // back-to-back accept+consume: a new bundle every cycle
        ex_ready_i = 1'b1;
        if_valid_i = 1'b1;
        for (int k = 0; k < 14; k++) begin
            instr_i = v[k].instr;
            pc_i    = 32'h1000 + 32'(k * 4);
            tick();
            chk({v[k].name, "_valid"}, 96'(ex_valid_o), 96'(1'b1));
            chk({v[k].name, "_pc"}, 96'(pc_o), 96'(32'h1000 + 32'(k * 4)));
            chk(v[k].name, 96'(act()), 96'(v[k].e));
        end

        if_valid_i = 1'b0;
        tick();
        chk("drain_valid", 96'(ex_valid_o), 96'(1'b0));

        // stall for 3 cycles with LUI queued behind ADDI
        if_valid_i = 1'b1;
        instr_i    = v[0].instr;
        pc_i       = 32'h2000;
        tick();
        ex_ready_i = 1'b0;
        instr_i    = v[1].instr;
        pc_i       = 32'h2004;
        #1;
        chk("stall_ready", 96'(if_ready_o), 96'(1'b0));
        snap = v[0].e;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold", 96'(act()), 96'(snap));
            chk("stall_pc", 96'(pc_o), 96'(32'h2000));
            chk("stall_valid", 96'(ex_valid_o), 96'(1'b1));
            chk("stall_rdy", 96'(if_ready_o), 96'(1'b0));
        end
        ex_ready_i = 1'b1;
        #1;
        chk("unstall_ready", 96'(if_ready_o), 96'(1'b1));
        tick();
        chk("unstall_lui", 96'(act()), 96'(v[1].e));
        chk("unstall_pc", 96'(pc_o), 96'(32'h2004));
        chk("unstall_valid", 96'(ex_valid_o), 96'(1'b1));

        // flush with an incoming valid beat
        instr_i = v[4].instr;
        flush_i = 1'b1;
        tick();
        chk("flush_valid", 96'(ex_valid_o), 96'(1'b0));
        flush_i = 1'b0;

        // flush while stalled
        instr_i = v[0].instr;
        tick();
        chk("pre_fs_valid", 96'(ex_valid_o), 96'(1'b1));
        ex_ready_i = 1'b0;
        flush_i    = 1'b1;
        tick();
        chk("flush_stall", 96'(ex_valid_o), 96'(1'b0));
        flush_i = 1'b0;

        // reset while stalled clears valid and payload
        ex_ready_i = 1'b1;
        instr_i    = v[10].instr;
        tick();
        chk("pre_rs_imm", 96'(imm), 96'(32'hFFFFFFF8));
        ex_ready_i = 1'b0;
        reset      = 1'b1;
        tick();
        chk("rst_stall_valid", 96'(ex_valid_o), 96'(1'b0));
        chk("rst_stall_imm", 96'(imm), 96'(0));
        chk("rst_stall_all", 96'(act()), 96'(0));
        reset = 1'b0;
        #1;
        chk("rst_stall_ready", 96'(if_ready_o), 96'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
